// File: rtl/tile_cfg_pkg.sv
// tile_cfg_pkg: shared FSM states, CRC polynomial and clog2 helper for the tile config loader
package tile_cfg_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/tile_cfg_crc8.sv
// tile_cfg_crc8: combinational CRC-8 (MSB-first) step over DATA_W bits folded LSB byte first
module tile_cfg_crc8 import tile_cfg_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic [7:0]        crc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [7:0]        crc_o
);
  localparam int NBYTES = (DATA_W + 7) / 8;
  logic [NBYTES*8-1:0] pad;
  // fold each byte into the running CRC, shifting out one bit at a time
  always_comb begin
    pad = (NBYTES*8)'(data_i);
    crc_o = crc_i;
    for (int b = 0; b < NBYTES; b++) begin
      crc_o = crc_o ^ pad[b*8 +: 8];
      for (int k = 0; k < 8; k++)
        crc_o = crc_o[7] ? {crc_o[6:0], 1'b0} ^ CRC8_POLY : {crc_o[6:0], 1'b0};
    end
  end
endmodule

// File: rtl/tile_config_loader.sv
// tile_config_loader: decodes tile config writes into per-element strobes with bursts and error flags; TILE_CFG_CRC_EN adds a CRC-8 of committed data
module tile_config_loader import tile_cfg_pkg::*; #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int NB_ELEM = 2,
  parameter int LEN_W   = 8,
  parameter int WCNT_W  = 16,
  localparam int IDX_W       = clog2(NB_ELEM),
  localparam int ELEM_ADDR_W = ADDR_W - IDX_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   select_tile,
  output logic                   cfg_ready,
  input  logic [ADDR_W-1:0]      address_tile,
  input  logic [DATA_W-1:0]      data_tile,
  input  logic                   burst_tile,
  input  logic [LEN_W-1:0]       burst_len,
  input  logic                   err_clr,
  output logic [NB_ELEM-1:0]     elem_select,
  output logic [ELEM_ADDR_W-1:0] elem_address,
  output logic [DATA_W-1:0]      elem_data,
  output logic                   busy,
  output logic                   err_addr,
  output logic                   err_wrap,
  output logic [WCNT_W-1:0]      write_count,
  output logic [7:0]             crc
);
  localparam logic [IDX_W:0]     NB  = (IDX_W+1)'(NB_ELEM);
  localparam logic [NB_ELEM-1:0] ONE = NB_ELEM'(1);
  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [IDX_W-1:0]       idx_q, idx_d, idx_n;
  logic [ELEM_ADDR_W-1:0] loc_q, loc_d, loc_n;
  logic [NB_ELEM-1:0]     sel_q, sel_d;
  logic [ELEM_ADDR_W-1:0] eaddr_q, eaddr_d;
  logic [DATA_W-1:0]      edata_q, edata_d;
  logic                   ea_q, ea_d, ew_q, ew_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic                   acc, first, ok, wrap, commit;
  // no backpressure source yet; ready in both IDLE and BURST
  assign cfg_ready = 1'b1;
  // beat decode: first beat samples the address, burst beats auto-increment within the element
  always_comb begin
    acc     = select_tile & cfg_ready;
    first   = state_q == IDLE;
    idx_n   = first ? address_tile[ADDR_W-1 -: IDX_W] : idx_q;
    loc_n   = first ? address_tile[ELEM_ADDR_W-1:0] : loc_q + 1'b1;
    ok      = {1'b0, idx_n} < NB;
    wrap    = !first && (&loc_q);
    commit  = acc && ok;
    state_d = !acc ? state_q : first ? ((burst_tile && burst_len > LEN_W'(1)) ? BURST : IDLE)
                                     : (rem_q == LEN_W'(1) ? IDLE : BURST);
    rem_d   = !acc ? rem_q : first ? burst_len - 1'b1 : rem_q - 1'b1;
    idx_d   = acc ? idx_n : idx_q;
    loc_d   = acc ? loc_n : loc_q;
    sel_d   = commit ? ONE << idx_n : '0;
    eaddr_d = commit ? loc_n : eaddr_q;
    edata_d = commit ? data_tile : edata_q;
    ea_d    = (acc && !ok) || (ea_q && !err_clr);
    ew_d    = (acc && wrap) || (ew_q && !err_clr);
    wcnt_d  = (commit && !(&wcnt_q)) ? wcnt_q + 1'b1 : wcnt_q;
  end
  // FSM and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      loc_q   <= '0;
      sel_q   <= '0;
      eaddr_q <= '0;
      edata_q <= '0;
      ea_q    <= 1'b0;
      ew_q    <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      loc_q   <= loc_d;
      sel_q   <= sel_d;
      eaddr_q <= eaddr_d;
      edata_q <= edata_d;
      ea_q    <= ea_d;
      ew_q    <= ew_d;
      wcnt_q  <= wcnt_d;
    end
  end
  assign elem_select  = sel_q;
  assign elem_address = eaddr_q;
  assign elem_data    = edata_q;
  assign busy         = state_q == BURST;
  assign err_addr     = ea_q;
  assign err_wrap     = ew_q;
  assign write_count  = wcnt_q;
`ifdef TILE_CFG_CRC_EN
  logic [7:0] crc_q, crc_d, crc_n;
  tile_cfg_crc8 #(.DATA_W(DATA_W)) u_crc (.crc_i(crc_q), .data_i(edata_q), .crc_o(crc_n));
  // fold the data of each strobe into the CRC the cycle after it is presented
  always_comb crc_d = |sel_q ? crc_n : crc_q;
  // CRC register
  always_ff @(posedge clock) crc_q <= reset ? 8'h00 : crc_d;
  assign crc = crc_q;
`else
  assign crc = 8'h00;
`endif
endmodule

// File: tb/tb_tile_config_loader.sv
// tb_tile_config_loader: vector table, corner sequences and a randomized reference-model run
module tb_tile_config_loader;
`ifdef TILE_CFG_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, sv, bt, ec;
  logic [9:0] at;
  logic [7:0] dt, bl;
  logic rdy, busy, eaf, ewf;
  logic [1:0] sel;
  logic [8:0] ea;
  logic [7:0] ed, crc;
  logic [15:0] wc;
  logic rdy3, busy3, eaf3, ewf3;
  logic [2:0] sel3;
  logic [7:0] ea3, ed3, crc3;
  logic [15:0] wc3;
  int n_chk = 0, n_fail = 0;

  tile_config_loader u_dut (
    .clock(clk), .reset(rst), .select_tile(sv), .cfg_ready(rdy), .address_tile(at),
    .data_tile(dt), .burst_tile(bt), .burst_len(bl), .err_clr(ec), .elem_select(sel),
    .elem_address(ea), .elem_data(ed), .busy(busy), .err_addr(eaf), .err_wrap(ewf),
    .write_count(wc), .crc(crc));

  tile_config_loader #(.NB_ELEM(3)) u_dut3 (
    .clock(clk), .reset(rst), .select_tile(sv), .cfg_ready(rdy3), .address_tile(at),
    .data_tile(dt), .burst_tile(bt), .burst_len(bl), .err_clr(ec), .elem_select(sel3),
    .elem_address(ea3), .elem_data(ed3), .busy(busy3), .err_addr(eaf3), .err_wrap(ewf3),
    .write_count(wc3), .crc(crc3));

  typedef struct {
    logic sv; logic [9:0] a; logic [7:0] d; logic bt; logic [7:0] bl; logic ec;
    logic [1:0] sel; logic [8:0] ad; logic [7:0] dat; logic busy; logic ew; logic [15:0] wc;
  } vec_t;
  vec_t tbl[13];

  bit m_busy, m_ea, m_ew;
  int m_rem, m_idx, m_loc, m_wc;
  logic [1:0] m_sel;
  logic [8:0] m_addr;
  logic [7:0] m_data, m_crc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [9:0] a, input logic [7:0] d,
                       input logic b, input logic [7:0] l, input logic c);
    sv = s; at = a; dt = d; bt = b; bl = l; ec = c;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // behavioural model of the default (2-element, 9-bit local address) loader, one call per clock
  task automatic model;
    bit wrap, bad;
    wrap = 0; bad = 0;
    if (m_sel != 0) m_crc = crc_upd(m_crc, m_data);
    m_sel = 0;
    if (rst) begin
      m_busy = 0; m_rem = 0; m_idx = 0; m_loc = 0; m_addr = 0; m_data = 0;
      m_crc = 0; m_ea = 0; m_ew = 0; m_wc = 0;
    end else begin
      if (sv) begin
        if (!m_busy) begin
          m_idx = int'(at) / 512;
          m_loc = int'(at) % 512;
          if (bt && bl > 1) begin m_busy = 1; m_rem = int'(bl) - 1; end
        end else begin
          wrap = m_loc == 511;
          m_loc = (m_loc + 1) % 512;
          m_rem--;
          if (m_rem == 0) m_busy = 0;
        end
        if (m_idx < 2) begin
          m_sel = 2'(1 << m_idx);
          m_addr = 9'(m_loc);
          m_data = dt;
          if (m_wc < 65535) m_wc++;
        end else bad = 1;
      end
      m_ea = bad || (m_ea && !ec);
      m_ew = wrap || (m_ew && !ec);
    end
  endtask

  initial begin
    tbl[0]  = '{1, 10'h205, 8'hA5, 0, 0, 0, 2'b10, 9'h005, 8'hA5, 0, 0, 16'd1};
    tbl[1]  = '{0, 10'h000, 8'h00, 0, 0, 0, 2'b00, 9'h005, 8'hA5, 0, 0, 16'd1};
    tbl[2]  = '{1, 10'h010, 8'h01, 1, 4, 0, 2'b01, 9'h010, 8'h01, 1, 0, 16'd2};
    tbl[3]  = '{1, 10'h3FF, 8'h02, 0, 0, 0, 2'b01, 9'h011, 8'h02, 1, 0, 16'd3};
    tbl[4]  = '{0, 10'h000, 8'hEE, 0, 0, 0, 2'b00, 9'h011, 8'h02, 1, 0, 16'd3};
    tbl[5]  = '{1, 10'h000, 8'h03, 0, 0, 0, 2'b01, 9'h012, 8'h03, 1, 0, 16'd4};
    tbl[6]  = '{1, 10'h000, 8'h04, 0, 0, 0, 2'b01, 9'h013, 8'h04, 0, 0, 16'd5};
    tbl[7]  = '{1, 10'h1FE, 8'h11, 1, 3, 0, 2'b01, 9'h1FE, 8'h11, 1, 0, 16'd6};
    tbl[8]  = '{1, 10'h000, 8'h12, 0, 0, 0, 2'b01, 9'h1FF, 8'h12, 1, 0, 16'd7};
    tbl[9]  = '{1, 10'h000, 8'h13, 0, 0, 0, 2'b01, 9'h000, 8'h13, 0, 1, 16'd8};
    tbl[10] = '{0, 10'h000, 8'h00, 0, 0, 1, 2'b00, 9'h000, 8'h13, 0, 0, 16'd8};
    tbl[11] = '{1, 10'h0AB, 8'h5C, 1, 0, 0, 2'b01, 9'h0AB, 8'h5C, 0, 0, 16'd9};
    tbl[12] = '{1, 10'h300, 8'h77, 1, 1, 0, 2'b10, 9'h100, 8'h77, 0, 0, 16'd10};

    do_reset;
    chk("rst.ready", 32'(rdy), 32'd1);
    chk("rst.sel", 32'(sel), 32'd0);
    chk("rst.addr", 32'(ea), 32'd0);
    chk("rst.data", 32'(ed), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.err", 32'({eaf, ewf}), 32'd0);
    chk("rst.wcnt", 32'(wc), 32'd0);
    chk("rst.crc", 32'(crc), 32'd0);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].sv, tbl[i].a, tbl[i].d, tbl[i].bt, tbl[i].bl, tbl[i].ec);
      step;
      chk($sformatf("v%0d.sel", i), 32'(sel), 32'(tbl[i].sel));
      chk($sformatf("v%0d.addr", i), 32'(ea), 32'(tbl[i].ad));
      chk($sformatf("v%0d.data", i), 32'(ed), 32'(tbl[i].dat));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d.err_wrap", i), 32'(ewf), 32'(tbl[i].ew));
      chk($sformatf("v%0d.wcnt", i), 32'(wc), 32'(tbl[i].wc));
      chk($sformatf("v%0d.ready", i), 32'(rdy), 32'd1);
    end

    do_reset;
    drive(1, 10'h010, 8'h01, 1, 4, 0); step;
    drive(1, 10'h000, 8'h02, 0, 0, 0); step;
    chk("midrst.busy_before", 32'(busy), 32'd1);
    drive(1, 10'h000, 8'h03, 0, 0, 0); rst = 1'b1; step; rst = 1'b0;
    chk("midrst.sel", 32'(sel), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.wcnt", 32'(wc), 32'd0);
    chk("midrst.addr", 32'(ea), 32'd0);
    drive(1, 10'h205, 8'hA5, 0, 0, 0); step;
    chk("midrst.new_sel", 32'(sel), 32'd2);
    chk("midrst.new_addr", 32'(ea), 32'h005);
    chk("midrst.new_wcnt", 32'(wc), 32'd1);

    do_reset;
    drive(1, 10'h000, 8'h01, 0, 0, 0); step;
    drive(0, 10'h000, 8'h00, 0, 0, 0); step;
    chk("crc.single01", 32'(crc), CRC_ON ? 32'h07 : 32'h00);

    do_reset;
    drive(1, 10'h300, 8'h77, 0, 0, 0); step;
    chk("e3.bad_sel", 32'(sel3), 32'd0);
    chk("e3.bad_err", 32'(eaf3), 32'd1);
    chk("e3.bad_wcnt", 32'(wc3), 32'd0);
    chk("e3.bad_ready", 32'(rdy3), 32'd1);
    drive(1, 10'h2AB, 8'h09, 0, 0, 0); step;
    chk("e3.ok_sel", 32'(sel3), 32'h4);
    chk("e3.ok_addr", 32'(ea3), 32'hAB);
    chk("e3.ok_wcnt", 32'(wc3), 32'd1);
    chk("e3.sticky", 32'(eaf3), 32'd1);
    drive(1, 10'h300, 8'h55, 0, 0, 1); step;
    chk("e3.set_wins", 32'(eaf3), 32'd1);
    drive(0, 10'h000, 8'h00, 0, 0, 1); step;
    chk("e3.clr", 32'(eaf3), 32'd0);
    drive(1, 10'h3F0, 8'h01, 1, 3, 0); step;
    chk("e3.bb1_sel", 32'(sel3), 32'd0);
    chk("e3.bb1_busy", 32'(busy3), 32'd1);
    drive(1, 10'h000, 8'h02, 0, 0, 0); step;
    chk("e3.bb2_sel", 32'(sel3), 32'd0);
    drive(1, 10'h000, 8'h03, 0, 0, 0); step;
    chk("e3.bb3_sel", 32'(sel3), 32'd0);
    chk("e3.bb3_busy", 32'(busy3), 32'd0);
    chk("e3.bb3_wcnt", 32'(wc3), 32'd1);
    chk("e3.bb3_err", 32'(eaf3), 32'd1);
    chk("e3.bb3_ready", 32'(rdy3), 32'd1);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model; step;
    rst = 1'b0;
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom % 80) == 0;
      sv = ($urandom % 4) != 0;
      at = 10'($urandom);
      if ($urandom % 4 == 0) at[8:0] = 9'h1FC | 9'($urandom % 4);
      dt = 8'($urandom);
      bt = ($urandom % 3) == 0;
      bl = 8'($urandom % 6);
      ec = ($urandom % 16) == 0;
      model;
      step;
      chk($sformatf("r%0d.sel", n), 32'(sel), 32'(m_sel));
      chk($sformatf("r%0d.addr", n), 32'(ea), 32'(m_addr));
      chk($sformatf("r%0d.data", n), 32'(ed), 32'(m_data));
      chk($sformatf("r%0d.busy", n), 32'(busy), 32'(m_busy));
      chk($sformatf("r%0d.err_addr", n), 32'(eaf), 32'(m_ea));
      chk($sformatf("r%0d.err_wrap", n), 32'(ewf), 32'(m_ew));
      chk($sformatf("r%0d.wcnt", n), 32'(wc), 32'(m_wc));
      chk($sformatf("r%0d.crc", n), 32'(crc), CRC_ON ? 32'(m_crc) : 32'h0);
      chk($sformatf("r%0d.ready", n), 32'(rdy), 32'd1);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
